dmem_responder: RTL and testbench

- Memory-side target for the core's data-memory port: it accepts load/store requests over a valid/ready handshake.
- Byte-strobe stores are committed into an internal word array; load data is returned after a programmable number of wait states.
- Stands in for the combinational data memory when the core moves to a stall-capable memory interface. It also serves as the bench model for that interface.

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Valid/ready data-memory bus between the core (master) and a memory target (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side target for the core data port: byte-strobe stores into a word array,
// loads answered after WAIT_STATES extra cycles, range/alignment errors flagged.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_STATES = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN     = 33'd1 << (ADDR_WIDTH + 2);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [3:0]  we_reg;
  logic [31:0] wdata_reg;
  logic        req_ready_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [31:0] mem [DEPTH];

  logic [31:0]           cur_addr;
  logic [3:0]            cur_we;
  logic [31:0]           cur_wdata;
  logic [31:0]           offset;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  enter_resp;
  logic                  commit_store;
  logic [3:0]            lane_wen;

  // With zero wait states the commit happens on the accept edge itself, so the
  // live request is used while idle and the latched copy otherwise.
  always_comb begin
    cur_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
    cur_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
    cur_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
    offset    = cur_addr - BASE_ADDR;
    addr_ok   = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN) && (cur_addr[1:0] == 2'b00);
    word_idx  = offset[ADDR_WIDTH+1:2];
    accept    = (state_reg == IDLE) && bus.req_valid;
    enter_resp = (accept && (WAIT_STATES == 0)) || ((state_reg == WAIT) && (cnt_reg == 4'd0));
    commit_store = enter_resp && addr_ok && (cur_we != 4'b0000);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_wen[gi] = commit_store & cur_we[gi];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_wen[i]) mem[word_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= 32'd0;
      we_reg        <= 4'd0;
      wdata_reg     <= 32'd0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg      <= bus.req_addr;
            we_reg        <= bus.req_we;
            wdata_reg     <= bus.req_wdata;
            req_ready_reg <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
      // Load data is the word as it stands before any store on this same edge.
      if (enter_resp) begin
        rsp_rdata_reg <= (addr_ok && (cur_we == 4'b0000)) ? mem[word_idx] : 32'd0;
        rsp_err_reg   <= !addr_ok;
      end
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT_STATES 2, 0, 3) share one
// stimulus set, selected by sel; expected values are hand-computed constants.
module tb_dmem_responder;
  logic        clk;
  logic [2:0]  rst_v;
  int          sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int n_checks;
  int n_pass;

  dmem_if if_a ();
  dmem_if if_b ();
  dmem_if if_c ();

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2))
    dut_a (.clk(clk), .reset(rst_v[0]), .bus(if_a.slave));
  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0))
    dut_b (.clk(clk), .reset(rst_v[1]), .bus(if_b.slave));
  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3))
    dut_c (.clk(clk), .reset(rst_v[2]), .bus(if_c.slave));

  assign if_a.req_valid = req_valid && (sel == 0);
  assign if_b.req_valid = req_valid && (sel == 1);
  assign if_c.req_valid = req_valid && (sel == 2);
  assign if_a.req_addr  = req_addr;
  assign if_b.req_addr  = req_addr;
  assign if_c.req_addr  = req_addr;
  assign if_a.req_we    = req_we;
  assign if_b.req_we    = req_we;
  assign if_c.req_we    = req_we;
  assign if_a.req_wdata = req_wdata;
  assign if_b.req_wdata = req_wdata;
  assign if_c.req_wdata = req_wdata;
  assign if_a.rsp_ready = rsp_ready;
  assign if_b.rsp_ready = rsp_ready;
  assign if_c.rsp_ready = rsp_ready;

  always_comb begin
    o_req_ready = if_a.req_ready;
    o_rsp_valid = if_a.rsp_valid;
    o_rsp_rdata = if_a.rsp_rdata;
    o_rsp_err   = if_a.rsp_err;
    if (sel == 1) begin
      o_req_ready = if_b.req_ready;
      o_rsp_valid = if_b.rsp_valid;
      o_rsp_rdata = if_b.rsp_rdata;
      o_rsp_err   = if_b.rsp_err;
    end else if (sel == 2) begin
      o_req_ready = if_c.req_ready;
      o_rsp_valid = if_c.rsp_valid;
      o_rsp_rdata = if_c.rsp_rdata;
      o_rsp_err   = if_c.rsp_err;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One full transaction; hold>0 keeps rsp_ready low for that many cycles of RESP.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                         input int hold, output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'h0000_1000;
    req_we    = 4'hF;
    req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("rsp_timeout", 32'(o_rsp_valid), 32'd1);
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", 32'(o_rsp_valid), 32'd1);
      check_eq("hold_ready", 32'(o_req_ready), 32'd0);
      check_eq("hold_rdata", o_rsp_rdata, rdata);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("done_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("done_ready", 32'(o_req_ready), 32'd1);
    check_eq("done_rdata", o_rsp_rdata, 32'd0);
    $display("txn sel=%0d addr=%h we=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel, addr, we, wdata, rdata, err, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;
  int          acc_cyc[$];

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sel       = 0;
    rst_v     = 3'b111;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_we    = 4'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(o_req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    rst_v = 3'b000;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(o_req_ready), 32'd1);
    check_eq("post_rst_valid", 32'(o_rsp_valid), 32'd0);

    // store then load, WAIT_STATES=2
    run_txn(32'h0000_1010, 4'hF, 32'hDEAD_BEEF, 0, rd, er, lt);
    check_eq("st_lat", 32'(lt), 32'd3);
    check_eq("st_err", 32'(er), 32'd0);
    check_eq("st_rdata", rd, 32'd0);
    run_txn(32'h0000_1010, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("ld_lat", 32'(lt), 32'd3);
    check_eq("ld_err", 32'(er), 32'd0);
    check_eq("ld_rdata", rd, 32'hDEAD_BEEF);

    // byte-lane merge
    run_txn(32'h0000_1020, 4'hF, 32'h1122_3344, 0, rd, er, lt);
    run_txn(32'h0000_1020, 4'b0100, 32'h00AA_0000, 0, rd, er, lt);
    check_eq("lane_st_err", 32'(er), 32'd0);
    run_txn(32'h0000_1020, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("lane_merge", rd, 32'h11AA_3344);

    // range / alignment errors and the last legal word
    run_txn(32'h0000_0FFC, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("below_err", 32'(er), 32'd1);
    check_eq("below_rdata", rd, 32'd0);
    run_txn(32'h0000_2000, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("above_err", 32'(er), 32'd1);
    check_eq("above_rdata", rd, 32'd0);
    run_txn(32'h0000_1012, 4'hF, 32'h5555_5555, 0, rd, er, lt);
    check_eq("misal_err", 32'(er), 32'd1);
    check_eq("misal_rdata", rd, 32'd0);
    run_txn(32'h0000_1FFC, 4'hF, 32'h0BAD_F00D, 0, rd, er, lt);
    check_eq("top_st_err", 32'(er), 32'd0);
    run_txn(32'h0000_1FFC, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("top_ld_rdata", rd, 32'h0BAD_F00D);
    run_txn(32'h0000_1010, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("after_err_rdata", rd, 32'hDEAD_BEEF);
    check_eq("after_err_err", 32'(er), 32'd0);

    // backpressure: five cycles of rsp_ready low in RESP
    run_txn(32'h0000_1020, 4'h0, 32'd0, 5, rd, er, lt);
    check_eq("bp_rdata", rd, 32'h11AA_3344);

    // WAIT_STATES=0
    sel = 1;
    run_txn(32'h0000_1040, 4'hF, 32'h1234_5678, 0, rd, er, lt);
    check_eq("ws0_lat", 32'(lt), 32'd1);
    run_txn(32'h0000_1040, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("ws0_rdata", rd, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_1040;
    req_we    = 4'h0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (o_req_ready) acc_cyc.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("b2b_count", 32'(acc_cyc.size()), 32'd5);
    for (int k = 1; k < acc_cyc.size(); k++)
      check_eq("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);
    $display("txn sel=1 back-to-back accepts=%0d", acc_cyc.size());

    // reset mid-transaction, WAIT_STATES=3
    sel = 2;
    run_txn(32'h0000_1030, 4'hF, 32'h0000_0000, 0, rd, er, lt);
    check_eq("ws3_lat", 32'(lt), 32'd4);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_1030;
    req_we    = 4'hF;
    req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("pre_rst_ready", 32'(o_req_ready), 32'd0);
    rst_v[2] = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(o_req_ready), 32'd1);
    check_eq("midrst_valid", 32'(o_rsp_valid), 32'd0);
    $display("txn sel=2 store cafef00d aborted by reset");
    @(negedge clk);
    rst_v[2] = 1'b0;
    run_txn(32'h0000_1030, 4'h0, 32'd0, 0, rd, er, lt);
    check_eq("dropped_store", rd, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
